// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-mapped UART transmitter.
// Contents: register offsets inside the 4-byte window, STATUS bit positions
// and the transmit FSM state encoding.
package bus_uart_pkg;

  // Register offsets (bus_addr[1:0])
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  // STATUS bit positions; bits [7:4] read as zero
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // Transmit FSM
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead output.
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset (empties the FIFO)
//   push_i, din_i    write request and data; accepted when not full, or when
//                    full and a pop happens on the same edge
//   pop_i, dout_o    read request; dout_o always shows the oldest entry
//   full_o, empty_o  occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  // A pop on the same edge frees the slot being written, so full does not block
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign dout_o    = mem_q[rptr_q[AW-1:0]];

  // Read/write pointer update
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push_s) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter on the CPU bus.
// Ports:
//   clk, rst_n   core clock, synchronous active-low reset
//   bus_data     bidirectional data bus; driven only during a selected read
//   bus_addr     13-bit address; window of 4 bytes at BASE_ADDR
//   wr, rd       write / read strobes (active high)
//   txd          registered serial output, idles high
//   irq          registered "TX done": FIFO empty and shifter idle
// Register map: +0 TXDATA (wo), +1 STATUS, +2 DIV_LO, +3 DIV_HI.
// Bit period is DIV+1 clocks; one write action per wr pulse (rising edge).
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR  = 13'h1F20,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [7:0]  bus_data,
  input  logic [12:0] bus_addr,
  input  logic        wr,
  input  logic        rd,
  output logic        txd,
  output logic        irq
);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        txd_q, txd_d;
  logic        irq_q;
  logic        wr_q;
  logic        ovf_q;

  logic        sel_s;
  logic [1:0]  off_s;
  logic        wr_fire_s;
  logic [7:0]  wdata_s;
  logic [7:0]  status_s;
  logic [7:0]  rd_data_s;
  logic        tick_s;
  logic        push_s;
  logic        pop_s;
  logic [7:0]  fifo_dout_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  assign sel_s     = (bus_addr[12:2] == BASE_ADDR[12:2]);
  assign off_s     = bus_addr[1:0];
  assign wdata_s   = bus_data;
  assign wr_fire_s = wr && !wr_q && sel_s;
  // A TXDATA write into a full FIFO still lands if the shifter pops on this edge
  assign push_s    = wr_fire_s && (off_s == REG_TXDATA) && (!fifo_full_s || pop_s);
  assign tick_s    = (cnt_q == 16'd0);

  assign status_s  = {4'b0000, ovf_q, (state_q != S_IDLE), fifo_empty_s, fifo_full_s};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (wdata_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Read mux for the register window
  always_comb begin
    rd_data_s = 8'h00;
    case (off_s)
      REG_TXDATA: rd_data_s = 8'h00;
      REG_STATUS: rd_data_s = status_s;
      REG_DIV_LO: rd_data_s = div_q[7:0];
      REG_DIV_HI: rd_data_s = div_q[15:8];
      default:    rd_data_s = 8'h00;
    endcase
  end

  assign bus_data = (rd && sel_s) ? rd_data_s : 8'hzz;

  // Write-strobe edge detect, divisor and sticky overflow registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      div_q <= DIV_RESET;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr;
      if (wr_fire_s) begin
        case (off_s)
          REG_TXDATA: begin
            if (fifo_full_s && !pop_s) begin
              ovf_q <= 1'b1;
            end
          end
          REG_STATUS: begin
            if (wdata_s[STAT_OVF]) begin
              ovf_q <= 1'b0;
            end
          end
          REG_DIV_LO: div_q[7:0]  <= wdata_s;
          REG_DIV_HI: div_q[15:8] <= wdata_s;
          default: ;
        endcase
      end
    end
  end

  // Transmit FSM next state; the baud counter reloads from DIV at every bit
  // boundary, so divisor changes apply from the next bit period
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    txd_d    = txd_q;
    pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shreg_d = fifo_dout_s;
          txd_d   = 1'b0;
          cnt_d   = div_q;
          state_d = S_START;
        end else begin
          txd_d   = 1'b1;
        end
      end
      S_START: begin
        if (tick_s) begin
          cnt_d    = div_q;
          bitcnt_d = 3'd0;
          txd_d    = shreg_q[0];
          state_d  = S_DATA;
        end else begin
          cnt_d    = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          cnt_d = div_q;
          if (bitcnt_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            txd_d    = shreg_q[bitcnt_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tick_s) begin
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shreg_d = fifo_dout_s;
            txd_d   = 1'b0;
            cnt_d   = div_q;
            state_d = S_START;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      txd_q    <= 1'b1;
      irq_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      txd_q    <= txd_d;
      irq_q    <= fifo_empty_s && (state_q == S_IDLE);
    end
  end

  assign txd = txd_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx. Expected bytes go into a scoreboard
// queue when written; a serial monitor decodes txd frames and pops/compares.
module tb_bus_uart_tx;
  import bus_uart_pkg::*;

  localparam logic [12:0] BASE = 13'h1F20;

  logic        clk;
  logic        rst_n;
  wire  [7:0]  bus_data;
  logic [12:0] bus_addr;
  logic        wr;
  logic        rd;
  logic        txd;
  logic        irq;

  logic [7:0]  drv_data;
  logic        drv_en;
  assign bus_data = drv_en ? drv_data : 8'hzz;

  int          n_checks;
  int          n_fails;
  int          cyc;
  int          push_cyc;
  int          n_frames;
  int          tb_div;
  logic        mon_en;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  bus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd433)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_data (bus_data),
    .bus_addr (bus_addr),
    .wr       (wr),
    .rd       (rd),
    .txd      (txd),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d, input int len);
    @(negedge clk);
    bus_addr = BASE | {11'd0, off};
    drv_data = d;
    drv_en   = 1'b1;
    wr       = 1'b1;
    @(negedge clk);
    push_cyc = cyc;
    repeat (len - 1) @(negedge clk);
    wr     = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [7:0] d);
    @(negedge clk);
    bus_addr = BASE | {11'd0, off};
    rd = 1'b1;
    #1;
    d  = bus_data;
    rd = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int waited;
    waited = 0;
    while (n_frames < target && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check_val("frame_count", n_frames, target);
  endtask

  // Serial monitor: samples every cycle of every bit and requires stability
  initial begin : monitor
    logic [9:0] bits;
    logic       stable;
    int         per;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && txd == 1'b0) begin
        per = tb_div + 1;
        start_q.push_back(cyc);
        stable = 1'b1;
        bits   = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < per; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) stable = 1'b0;
          end
        end
        check_val("bit_stable", stable, 1);
        check_val("stop_bit", bits[9], 1);
        if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 1);
        else check_val("frame_data", bits[8:1], exp_q.pop_front());
        n_frames++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rv;
    logic       busy_all;
    int         base_i;
    int         n0;
    int         low_cnt;
    n_checks = 0; n_fails = 0; cyc = 0; n_frames = 0; tb_div = 433;
    mon_en = 1'b1; drv_en = 1'b0; drv_data = 8'h00;
    bus_addr = 13'h0000; wr = 1'b0; rd = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. reset state
    check_val("rst_txd", txd, 1);
    check_val("rst_irq", irq, 1);
    bus_read(REG_STATUS, rv); check_val("rst_status", rv, 8'h02);
    bus_read(REG_DIV_LO, rv); check_val("rst_div_lo", rv, 8'hB1);
    bus_read(REG_DIV_HI, rv); check_val("rst_div_hi", rv, 8'h01);
    bus_read(REG_TXDATA, rv); check_val("txdata_read", rv, 8'h00);

    // 2. single frame at DIV=3
    bus_write(REG_DIV_LO, 8'h03, 1);
    bus_write(REG_DIV_HI, 8'h00, 1);
    bus_read(REG_DIV_LO, rv); check_val("div_lo_rb", rv, 8'h03);
    tb_div = 3;
    base_i = start_q.size();
    exp_q.push_back(8'hA5);
    bus_write(REG_TXDATA, 8'hA5, 1);
    wait_frames(1, 100);
    if (start_q.size() > base_i) check_val("start_latency", start_q[base_i] - push_cyc, 1);
    else check_val("start_seen", start_q.size(), base_i + 1);
    repeat (3) @(negedge clk);
    check_val("irq_after", irq, 1);
    check_val("txd_idle", txd, 1);
    bus_read(REG_STATUS, rv); check_val("status_idle", rv, 8'h02);

    // 3. back-to-back frames, busy throughout
    base_i = start_q.size();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    bus_write(REG_TXDATA, 8'h55, 1);
    bus_write(REG_TXDATA, 8'h0F, 1);
    busy_all = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus_read(REG_STATUS, rv);
      busy_all = busy_all & rv[STAT_BUSY];
    end
    check_val("busy_b2b", busy_all, 1);
    wait_frames(3, 100);
    if (start_q.size() >= base_i + 2) check_val("b2b_gap", start_q[base_i + 1] - start_q[base_i], 40);
    else check_val("b2b_starts", start_q.size(), base_i + 2);

    // 4. fill FIFO, overflow, clear
    repeat (5) @(negedge clk);
    bus_write(REG_DIV_LO, 8'h64, 1);
    tb_div = 100;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'h30 + 8'(i));
      bus_write(REG_TXDATA, 8'h30 + 8'(i), 1);
    end
    bus_read(REG_STATUS, rv); check_val("status_full_ovf", rv, 8'h0D);
    bus_write(REG_STATUS, 8'h08, 1);
    bus_read(REG_STATUS, rv); check_val("status_ovf_clr", rv, 8'h05);
    wait_frames(12, 9500);
    repeat (300) @(negedge clk);
    check_val("frames_after_fill", n_frames, 12);
    check_val("sb_drained", exp_q.size(), 0);

    // 5. long wr pulse pushes exactly one byte
    bus_write(REG_DIV_LO, 8'h03, 1);
    tb_div = 3;
    n0 = n_frames;
    exp_q.push_back(8'h3C);
    bus_write(REG_TXDATA, 8'h3C, 5);
    bus_read(REG_STATUS, rv); check_val("status_long_wr", rv, 8'h06);
    wait_frames(n0 + 1, 100);
    repeat (80) @(negedge clk);
    check_val("one_push", n_frames, n0 + 1);

    // 6. reset during data bit 4
    mon_en = 1'b0;
    bus_write(REG_TXDATA, 8'hE1, 1);
    n0 = push_cyc;
    bus_write(REG_TXDATA, 8'h77, 1);
    while (cyc < n0 + 22) @(negedge clk);
    check_val("mid_bit4", txd, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_mid_txd", txd, 1);
    check_val("rst_mid_irq", irq, 1);
    bus_read(REG_STATUS, rv); check_val("rst_mid_status", rv, 8'h02);
    bus_read(REG_DIV_LO, rv); check_val("rst_mid_div_lo", rv, 8'hB1);
    bus_read(REG_DIV_HI, rv); check_val("rst_mid_div_hi", rv, 8'h01);
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd == 1'b0) low_cnt++;
    end
    check_val("no_frame_after_rst", low_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
